// File: rtl/pam_demod_pkg.sv
// Shared types and defaults for the PAM-4 threshold demodulator.
package pam_demod_pkg;

  typedef enum logic [1:0] {IDLE, TRAIN, DATA, DRAIN} state_t;

  typedef logic [1:0] sym_t;

  localparam int DEF_TRAIN_LEN   = 16;
  localparam int DEF_LENGTH_DATA = 1024;

  function automatic sym_t gray_map(input sym_t s);
    return s ^ (s >> 1);
  endfunction

endpackage

// File: rtl/pam4_thresh_demod_if.sv
// Sample stream from the synchroniser and symbol stream to bit recovery.
interface pam4_thresh_demod_if
  import pam_demod_pkg::*;
#(
  parameter int AD_CVER_WIDTH = 12
) ();

  logic                            syn_demodu_valid;
  logic signed [AD_CVER_WIDTH-1:0] syn_demodu_data;
  logic                            syn_demodu_ready;
  logic                            demod_valid;
  sym_t                            demod_sym;
  logic                            demod_last;
  logic                            demod_err;

  modport master (
    output syn_demodu_valid, syn_demodu_data,
    input  syn_demodu_ready, demod_valid, demod_sym, demod_last, demod_err
  );

  modport slave (
    input  syn_demodu_valid, syn_demodu_data,
    output syn_demodu_ready, demod_valid, demod_sym, demod_last, demod_err
  );

endinterface

// File: rtl/pam4_slicer.sv
// Final registered stage: counts thresholds exceeded and maps to a symbol.
// Gray output coding when PAM4_GRAY_MAP_EN is defined, natural binary otherwise.
module pam4_slicer
  import pam_demod_pkg::*;
#(
  parameter int AD_CVER_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [AD_CVER_WIDTH-1:0] u_i,
  input  logic [AD_CVER_WIDTH-1:0] thr0_i,
  input  logic [AD_CVER_WIDTH-1:0] thr1_i,
  input  logic [AD_CVER_WIDTH-1:0] thr2_i,
  input  logic                     vld_i,
  input  logic                     last_i,
  output sym_t                     sym_o,
  output logic                     vld_o,
  output logic                     last_o
);

  sym_t lvl;
  sym_t code;
  sym_t sym_p2;
  logic vld_p2;
  logic last_p2;

  always_comb begin
    lvl = {1'b0, (u_i > thr0_i)} + {1'b0, (u_i > thr1_i)} + {1'b0, (u_i > thr2_i)};
`ifdef PAM4_GRAY_MAP_EN
    code = gray_map(lvl);
`else
    code = lvl;
`endif
  end

  // stage p2: decided symbol register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sym_p2  <= '0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p2  <= vld_i;
      last_p2 <= vld_i & last_i;
      if (vld_i) sym_p2 <= code;
    end
  end

  assign sym_o  = sym_p2;
  assign vld_o  = vld_p2;
  assign last_o = last_p2;

endmodule

// File: rtl/pam4_thresh_demod.sv
// PAM-4 demodulator: learns four levels from a training block, then slices payload.
// Symbol coding selected by PAM4_GRAY_MAP_EN inside pam4_slicer.
module pam4_thresh_demod
  import pam_demod_pkg::*;
#(
  parameter int AD_CVER_WIDTH = 12,
  parameter int TRAIN_LEN     = DEF_TRAIN_LEN,
  parameter int LENGTH_DATA   = DEF_LENGTH_DATA
) (
  input logic                clk,
  input logic                arst_n,
  pam4_thresh_demod_if.slave bus
);

  localparam int W     = AD_CVER_WIDTH;
  localparam int SH    = $clog2(TRAIN_LEN / 4);
  localparam int ACC_W = W + SH;
  localparam int FRAME = TRAIN_LEN + LENGTH_DATA;
  localparam int CNT_W = $clog2(FRAME) + 1;

  function automatic logic [W-1:0] midpoint(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W:1];
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   sum_q [4];
  logic [ACC_W-1:0]   sum_d [4];
  logic [W-1:0]       thr_q [3];
  logic [W-1:0]       thr_c [3];
  logic [W-1:0]       mean  [4];
  logic               lat_q, lat_d;
  logic               err_q, ready_q;
  logic               abort, dvld, dlast, bad_lvl;
  logic [W-1:0]       u, u_p0, u_p1;
  logic               vld_p0, vld_p1, last_p0, last_p1;

  assign u = {~bus.syn_demodu_data[W-1], bus.syn_demodu_data[W-2:0]};

  always_comb begin
    for (int k = 0; k < 4; k++) mean[k] = sum_q[k][SH +: W];
    for (int k = 0; k < 3; k++) thr_c[k] = midpoint(mean[k], mean[k+1]);
    bad_lvl = !((mean[0] < mean[1]) && (mean[1] < mean[2]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = 1'b0;
    abort   = 1'b0;
    dvld    = 1'b0;
    dlast   = 1'b0;
    for (int k = 0; k < 4; k++) sum_d[k] = sum_q[k];
    case (state_q)
      IDLE: if (bus.syn_demodu_valid) begin
        state_d = TRAIN;
        cnt_d   = CNT_W'(1);
        for (int k = 0; k < 4; k++) sum_d[k] = '0;
        sum_d[0] = ACC_W'(u);
      end
      TRAIN: if (!bus.syn_demodu_valid) begin
        abort   = 1'b1;
        state_d = IDLE;
        for (int k = 0; k < 4; k++) sum_d[k] = '0;
      end else begin
        sum_d[cnt_q[1:0]] = sum_q[cnt_q[1:0]] + ACC_W'(u);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TRAIN_LEN - 1)) begin
          state_d = DATA;
          lat_d   = 1'b1;
        end
      end
      DATA: if (!bus.syn_demodu_valid) begin
        abort   = 1'b1;
        state_d = IDLE;
        for (int k = 0; k < 4; k++) sum_d[k] = '0;
      end else begin
        dvld  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FRAME - 1)) begin
          dlast   = 1'b1;
          state_d = DRAIN;
        end
      end
      // Swallow an over-long valid so it cannot be mistaken for a new frame.
      DRAIN: if (!bus.syn_demodu_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      for (int k = 0; k < 4; k++) sum_q[k] <= '0;
      for (int k = 0; k < 3; k++) thr_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      ready_q <= 1'b1;
      err_q   <= abort | (lat_q & bad_lvl);
      for (int k = 0; k < 4; k++) sum_q[k] <= sum_d[k];
      if (lat_q) for (int k = 0; k < 3; k++) thr_q[k] <= thr_c[k];
    end
  end

  // stage p0/p1: align payload with the thresholds latched after training
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      last_p0 <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p0  <= dvld;
      vld_p1  <= vld_p0;
      last_p0 <= dlast;
      last_p1 <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    u_p0 <= u;
    u_p1 <= u_p0;
  end

  pam4_slicer #(.AD_CVER_WIDTH(W)) u_slicer (
    .clk    (clk),
    .arst_n (arst_n),
    .u_i    (u_p1),
    .thr0_i (thr_q[0]),
    .thr1_i (thr_q[1]),
    .thr2_i (thr_q[2]),
    .vld_i  (vld_p1),
    .last_i (last_p1),
    .sym_o  (bus.demod_sym),
    .vld_o  (bus.demod_valid),
    .last_o (bus.demod_last)
  );

  assign bus.syn_demodu_ready = ready_q;
  assign bus.demod_err        = err_q;

endmodule

// File: tb/tb_pam4_thresh_demod.sv
// Directed bench for pam4_thresh_demod; honours PAM4_GRAY_MAP_EN for expected codes.
module tb_pam4_thresh_demod;
  import pam_demod_pkg::*;

  localparam int W  = 12;
  localparam int TL = 16;
  localparam int LD = 1024;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  pam4_thresh_demod_if #(.AD_CVER_WIDTH(W)) bus ();

  pam4_thresh_demod #(.AD_CVER_WIDTH(W), .TRAIN_LEN(TL), .LENGTH_DATA(LD)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_err   = 0;
  int n_lastp = 0;
  int exp_cyc[$], exp_sym[$], exp_last[$];
  int got_cyc[$], got_sym[$], got_last[$];
  int tr_u[4], pay_u[4], pay_s[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (arst_n) begin
      if (bus.demod_valid) begin
        got_cyc.push_back(cyc);
        got_sym.push_back(int'(bus.demod_sym));
        got_last.push_back(int'(bus.demod_last));
      end
      if (bus.demod_err)  n_err++;
      if (bus.demod_last) n_lastp++;
    end
  end

  function automatic logic [W-1:0] raw(input int uv);
    logic [W-1:0] v;
    v = W'(uv);
    return {~v[W-1], v[W-2:0]};
  endfunction

  function automatic int map_sym(input int s);
`ifdef PAM4_GRAY_MAP_EN
    if (s == 2) return 3;
    if (s == 3) return 2;
`endif
    return s;
  endfunction

  function automatic int first_bad();
    for (int i = 0; i < got_cyc.size() && i < exp_cyc.size(); i++)
      if (got_cyc[i] != exp_cyc[i] || got_sym[i] != exp_sym[i] || got_last[i] != exp_last[i])
        return i;
    return -1;
  endfunction

  function automatic string describe(input int i);
    return $sformatf("idx %0d got cyc=%0d sym=%0d last=%0d, required cyc=%0d sym=%0d last=%0d",
                     i, got_cyc[i], got_sym[i], got_last[i], exp_cyc[i], exp_sym[i], exp_last[i]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    exp_cyc.delete(); exp_sym.delete(); exp_last.delete();
    got_cyc.delete(); got_sym.delete(); got_last.delete();
    n_err   = 0;
    n_lastp = 0;
  endtask

  task automatic drive_frame(input int n_pay, input int extra);
    for (int i = 0; i < TL; i++) begin
      bus.syn_demodu_valid = 1'b1;
      bus.syn_demodu_data  = $signed(raw(tr_u[i % 4]));
      step();
    end
    for (int k = 0; k < n_pay; k++) begin
      bus.syn_demodu_data = $signed(raw(pay_u[k % 4]));
      exp_cyc.push_back(cyc + 3);
      exp_sym.push_back(map_sym(pay_s[k % 4]));
      exp_last.push_back((k == LD - 1) ? 1 : 0);
      step();
    end
    for (int e = 0; e < extra; e++) begin
      bus.syn_demodu_data = $signed(raw(pay_u[0]));
      step();
    end
    bus.syn_demodu_valid = 1'b0;
    bus.syn_demodu_data  = '0;
    step();
  endtask

  task automatic drain();
    repeat (6) step();
  endtask

  task automatic set_ideal();
    tr_u  = '{512, 1536, 2560, 3584};
    pay_u = '{512, 1536, 2560, 3584};
    pay_s = '{0, 1, 2, 3};
  endtask

  task automatic test_reset();
    bus.syn_demodu_valid = 1'b0;
    bus.syn_demodu_data  = '0;
    #12;
    n_tests++;
    if (bus.syn_demodu_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b, required 0", bus.syn_demodu_ready);
    end
    n_tests++;
    if ({bus.demod_valid, bus.demod_sym, bus.demod_last, bus.demod_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b, required 00000",
                         {bus.demod_valid, bus.demod_sym, bus.demod_last, bus.demod_err});
    end
    @(negedge clk);
    arst_n = 1'b1;
    step(); step();
    n_tests++;
    if (bus.syn_demodu_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b, required 1", bus.syn_demodu_ready);
    end
  endtask

  task automatic test_ideal();
    int b;
    set_ideal();
    clear_log();
    drive_frame(LD, 0);
    drain();
    n_tests++;
    if (got_cyc.size() != LD) begin
      n_fail++; $display("FAIL ideal_count: got %0d symbols, required %0d", got_cyc.size(), LD);
    end
    b = first_bad();
    n_tests++;
    if (b >= 0) begin n_fail++; $display("FAIL ideal_stream: %s", describe(b)); end
    n_tests++;
    if (n_lastp != 1) begin n_fail++; $display("FAIL ideal_last: got %0d pulses, required 1", n_lastp); end
    n_tests++;
    if (n_err != 0) begin n_fail++; $display("FAIL ideal_err: got %0d pulses, required 0", n_err); end
  endtask

  task automatic test_boundary();
    int b;
    tr_u = '{512, 1536, 2560, 3584};
    clear_log();
    pay_u = '{2048, 2049, 1024, 3073};
    pay_s = '{1, 2, 0, 3};
    drive_frame(LD, 0);
    pay_u = '{3072, 1025, 0, 4095};
    pay_s = '{2, 1, 0, 3};
    drive_frame(LD, 0);
    drain();
    n_tests++;
    if (got_cyc.size() != 2 * LD) begin
      n_fail++; $display("FAIL boundary_count: got %0d symbols, required %0d", got_cyc.size(), 2 * LD);
    end
    b = first_bad();
    n_tests++;
    if (b >= 0) begin n_fail++; $display("FAIL boundary_stream: %s", describe(b)); end
    n_tests++;
    if (n_err != 0) begin n_fail++; $display("FAIL boundary_err: got %0d pulses, required 0", n_err); end
  endtask

  task automatic test_abort();
    int b;
    set_ideal();
    clear_log();
    drive_frame(500, 0);
    drain();
    n_tests++;
    if (got_cyc.size() != 500) begin
      n_fail++; $display("FAIL abort_count: got %0d symbols, required 500", got_cyc.size());
    end
    b = first_bad();
    n_tests++;
    if (b >= 0) begin n_fail++; $display("FAIL abort_stream: %s", describe(b)); end
    n_tests++;
    if (n_err != 1) begin n_fail++; $display("FAIL abort_err: got %0d pulses, required 1", n_err); end
    n_tests++;
    if (n_lastp != 0) begin n_fail++; $display("FAIL abort_last: got %0d pulses, required 0", n_lastp); end
    clear_log();
    drive_frame(LD, 0);
    drain();
    n_tests++;
    if (got_cyc.size() != LD) begin
      n_fail++; $display("FAIL post_abort_count: got %0d symbols, required %0d", got_cyc.size(), LD);
    end
    b = first_bad();
    n_tests++;
    if (b >= 0) begin n_fail++; $display("FAIL post_abort_stream: %s", describe(b)); end
    n_tests++;
    if (n_lastp != 1) begin n_fail++; $display("FAIL post_abort_last: got %0d pulses, required 1", n_lastp); end
    n_tests++;
    if (n_err != 0) begin n_fail++; $display("FAIL post_abort_err: got %0d pulses, required 0", n_err); end
  endtask

  task automatic test_bad_training();
    int b;
    tr_u  = '{2048, 2048, 2048, 2048};
    pay_u = '{2048, 4095, 0, 2049};
    pay_s = '{0, 3, 0, 3};
    clear_log();
    drive_frame(LD, 0);
    drain();
    n_tests++;
    if (n_err != 1) begin n_fail++; $display("FAIL bad_train_err: got %0d pulses, required 1", n_err); end
    n_tests++;
    if (got_cyc.size() != LD) begin
      n_fail++; $display("FAIL bad_train_count: got %0d symbols, required %0d", got_cyc.size(), LD);
    end
    b = first_bad();
    n_tests++;
    if (b >= 0) begin n_fail++; $display("FAIL bad_train_stream: %s", describe(b)); end
    n_tests++;
    if (n_lastp != 1) begin n_fail++; $display("FAIL bad_train_last: got %0d pulses, required 1", n_lastp); end
  endtask

  task automatic test_back_to_back();
    int b;
    set_ideal();
    clear_log();
    drive_frame(LD, 20);
    drive_frame(LD, 0);
    drain();
    n_tests++;
    if (got_cyc.size() != 2 * LD) begin
      n_fail++; $display("FAIL b2b_count: got %0d symbols, required %0d", got_cyc.size(), 2 * LD);
    end
    b = first_bad();
    n_tests++;
    if (b >= 0) begin n_fail++; $display("FAIL b2b_stream: %s", describe(b)); end
    n_tests++;
    if (n_lastp != 2) begin n_fail++; $display("FAIL b2b_last: got %0d pulses, required 2", n_lastp); end
    n_tests++;
    if (n_err != 0) begin n_fail++; $display("FAIL b2b_err: got %0d pulses, required 0", n_err); end
  endtask

  task automatic test_reset_midframe();
    int b;
    set_ideal();
    for (int i = 0; i < TL + 10; i++) begin
      bus.syn_demodu_valid = 1'b1;
      bus.syn_demodu_data  = $signed(raw((i < TL) ? tr_u[i % 4] : pay_u[(i - TL) % 4]));
      step();
    end
    n_tests++;
    if (bus.demod_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre_valid: got %b, required 1", bus.demod_valid);
    end
    #2;
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.syn_demodu_ready, bus.demod_valid, bus.demod_last, bus.demod_err} !== 4'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b, required 0000",
                         {bus.syn_demodu_ready, bus.demod_valid, bus.demod_last, bus.demod_err});
    end
    bus.syn_demodu_valid = 1'b0;
    bus.syn_demodu_data  = '0;
    @(negedge clk);
    arst_n = 1'b1;
    step();
    clear_log();
    drive_frame(LD, 0);
    drain();
    n_tests++;
    if (got_cyc.size() != LD) begin
      n_fail++; $display("FAIL post_reset_count: got %0d symbols, required %0d", got_cyc.size(), LD);
    end
    b = first_bad();
    n_tests++;
    if (b >= 0) begin n_fail++; $display("FAIL post_reset_stream: %s", describe(b)); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_boundary();
    test_abort();
    test_bad_training();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
